// File: rtl/hazard5_bp_pkg.sv
// hazard5_bp_pkg
// Shared branch-prediction definitions for the Hazard5 decode stage.
//   - bp_ctr_t      : 2-bit saturating counter encodings (SNT, WNT, WT, ST)
//   - bp_ctr_update : saturating increment/decrement of one counter
// No ports (package).
package hazard5_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_ctr_t;

  // Move a counter one step towards the resolved direction, clamping at
  // SNT and ST so a long run in one direction cannot wrap the counter.
  function automatic logic [1:0] bp_ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken) begin
      if (ctr != ST) result = ctr + 2'd1;
    end else begin
      if (ctr != SNT) result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hazard5_bht.sv
// hazard5_bht
// Branch history table: DEPTH 2-bit saturating counters, one asynchronous
// read port for prediction in D and one training write port driven from X.
// A read and write to the same index in one cycle returns the old value,
// since the write lands on the clock edge.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset, all counters to INIT
//   rd_idx   in  prediction index
//   rd_taken out MSB of the addressed counter (predict taken)
//   wr_en    in  train the counter at wr_idx
//   wr_idx   in  training index
//   wr_taken in  resolved direction (up if 1, down if 0)
module hazard5_bht
  import hazard5_bp_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [1:0] INIT  = 2'b01,
  localparam int        IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [DEPTH-1:0][1:0] ctr_q;

  // One register per entry so every counter can be reset in a single cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [1:0] ctr_reg;
      logic       hit;

      assign hit = wr_en && (wr_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          ctr_reg <= INIT;
        end else if (hit) begin
          ctr_reg <= bp_ctr_update(ctr_reg, wr_taken);
        end
      end

      assign ctr_q[gi] = ctr_reg;
    end
  endgenerate

  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/hazard5_decode_pc.sv
// hazard5_decode_pc
// Decode-stage PC, jump-request and CIR-lock controller for Hazard5.
// Holds the decode PC, raises jump requests towards fetch for JAL and for
// branches predicted taken, locks the CIR when a jump is accepted while D is
// stalled, and precomputes the mispredict-recovery / link address for X.
// Configuration macro: HAZARD5_BHT_EN
//   defined   - BHT_DEPTH-entry table of 2-bit counters, trained by x_br_*
//   undefined - static backward-taken prediction (sign of d_imm_b)
// Ports:
//   clk, rst (sync, active-high)
//   d_instr_vld, d_instr_is_32bit, d_is_branch, d_is_jal, d_imm_b, d_imm_j
//   x_stall, flush_d_x
//   f_jump_rdy, f_jump_now, f_jump_target
//   x_br_resolve, x_br_pc, x_br_taken   (BHT training)
//   d_pc, d_stall, d_jump_req, d_jump_target, df_cir_lock, d_pred_taken
//   dx_pred_taken, dx_mispredict_addr
module hazard5_decode_pc
  import hazard5_bp_pkg::*;
#(
  parameter int                W_ADDR       = 32,
  parameter logic [W_ADDR-1:0] RESET_VECTOR = '0,
  parameter int                BHT_DEPTH    = 16,
  parameter logic [1:0]        BHT_INIT     = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_instr_vld,
  input  logic              d_instr_is_32bit,
  input  logic              d_is_branch,
  input  logic              d_is_jal,
  input  logic [W_ADDR-1:0] d_imm_b,
  input  logic [W_ADDR-1:0] d_imm_j,
  input  logic              x_stall,
  input  logic              flush_d_x,
  input  logic              f_jump_rdy,
  input  logic              f_jump_now,
  input  logic [W_ADDR-1:0] f_jump_target,
  input  logic              x_br_resolve,
  input  logic [W_ADDR-1:0] x_br_pc,
  input  logic              x_br_taken,
  output logic [W_ADDR-1:0] d_pc,
  output logic              d_stall,
  output logic              d_jump_req,
  output logic [W_ADDR-1:0] d_jump_target,
  output logic              df_cir_lock,
  output logic              d_pred_taken,
  output logic              dx_pred_taken,
  output logic [W_ADDR-1:0] dx_mispredict_addr
);

  logic [W_ADDR-1:0] pc_reg;
  logic [W_ADDR-1:0] pc_next;
  logic              lock_prev_reg;
  logic              dx_pred_taken_reg;
  logic [W_ADDR-1:0] dx_mispredict_addr_reg;
  logic              jump_enable;
  logic              assert_lock;

  assign pc_next = pc_reg + (d_instr_is_32bit ? W_ADDR'(4) : W_ADDR'(2));

  // ---------------------------------------------------------------------------
  // Prediction
`ifdef HAZARD5_BHT_EN
  localparam int BHT_IDX_W = $clog2(BHT_DEPTH);

  // Halfword-aligned PCs: bit 0 carries no information, index from bit 1.
  hazard5_bht #(
    .DEPTH (BHT_DEPTH),
    .INIT  (BHT_INIT)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_reg[BHT_IDX_W:1]),
    .rd_taken (d_pred_taken),
    .wr_en    (x_br_resolve),
    .wr_idx   (x_br_pc[BHT_IDX_W:1]),
    .wr_taken (x_br_taken)
  );

  logic unused_br_pc_bits;
  assign unused_br_pc_bits = ^{x_br_pc[W_ADDR-1:BHT_IDX_W+1], x_br_pc[0]};
`else
  // Backward branches (negative offset) are predicted taken.
  assign d_pred_taken = d_imm_b[W_ADDR-1];

  logic unused_bht_inputs;
  assign unused_bht_inputs = ^{x_br_resolve, x_br_taken, x_br_pc, BHT_INIT, BHT_DEPTH[0]};
`endif

  // ---------------------------------------------------------------------------
  // Jump request, stall and CIR lock
  assign d_jump_target = pc_reg + (d_is_jal ? d_imm_j : d_imm_b);

  // An instruction that is held locked in the CIR has already issued its
  // jump, so it must not request again.
  assign jump_enable = d_instr_vld & ~lock_prev_reg;
  assign d_jump_req  = jump_enable & (d_is_jal | (d_is_branch & d_pred_taken));
  assign d_stall     = x_stall | ~d_instr_vld | (d_jump_req & ~f_jump_rdy);
  assign assert_lock = d_jump_req & f_jump_rdy & d_stall;
  assign df_cir_lock = (lock_prev_reg & d_stall) | assert_lock;

  // ---------------------------------------------------------------------------
  // State
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg                 <= RESET_VECTOR;
      lock_prev_reg          <= 1'b0;
      dx_pred_taken_reg      <= 1'b0;
      dx_mispredict_addr_reg <= '0;
    end else begin
      lock_prev_reg <= df_cir_lock;

      // A jump taken by fetch overrides sequential advance; while locked the
      // PC only moves with fetch jumps.
      if (f_jump_now) begin
        pc_reg <= f_jump_target;
      end else if (!d_stall && !lock_prev_reg) begin
        pc_reg <= pc_next;
      end

      // Capture on the lock edge too, so a jump accepted under stall still
      // hands X the correct link / fallthrough address.
      if (assert_lock || (!x_stall && !lock_prev_reg)) begin
        if (d_is_branch && !d_pred_taken) begin
          dx_mispredict_addr_reg <= pc_reg + d_imm_b;
        end else begin
          dx_mispredict_addr_reg <= pc_next;
        end
      end

      // A bubble enters X when D stalls while X moves on, or on a flush.
      // When X itself is stalled, its instruction and prediction are held.
      if (flush_d_x || (d_stall && !x_stall)) begin
        dx_pred_taken_reg <= 1'b0;
      end else if (!x_stall) begin
        dx_pred_taken_reg <= d_is_branch & d_pred_taken;
      end
    end
  end

  assign d_pc               = pc_reg;
  assign dx_pred_taken      = dx_pred_taken_reg;
  assign dx_mispredict_addr = dx_mispredict_addr_reg;

endmodule

// File: tb/tb_hazard5_decode_pc.sv
// tb_hazard5_decode_pc
// Self-checking bench for hazard5_decode_pc: directed scenarios followed by
// randomized cycles, every cycle compared against a behavioural model.
// Works with and without HAZARD5_BHT_EN.
module tb_hazard5_decode_pc;

  localparam int W     = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_instr_vld, d_instr_is_32bit, d_is_branch, d_is_jal;
  logic [W-1:0]  d_imm_b, d_imm_j;
  logic          x_stall, flush_d_x, f_jump_rdy, f_jump_now;
  logic [W-1:0]  f_jump_target;
  logic          x_br_resolve, x_br_taken;
  logic [W-1:0]  x_br_pc;
  logic [W-1:0]  d_pc, d_jump_target, dx_mispredict_addr;
  logic          d_stall, d_jump_req, df_cir_lock, d_pred_taken, dx_pred_taken;

  always #5 clk = ~clk;

  hazard5_decode_pc #(
    .W_ADDR       (W),
    .RESET_VECTOR (32'h0),
    .BHT_DEPTH    (DEPTH),
    .BHT_INIT     (2'b01)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .d_instr_vld        (d_instr_vld),
    .d_instr_is_32bit   (d_instr_is_32bit),
    .d_is_branch        (d_is_branch),
    .d_is_jal           (d_is_jal),
    .d_imm_b            (d_imm_b),
    .d_imm_j            (d_imm_j),
    .x_stall            (x_stall),
    .flush_d_x          (flush_d_x),
    .f_jump_rdy         (f_jump_rdy),
    .f_jump_now         (f_jump_now),
    .f_jump_target      (f_jump_target),
    .x_br_resolve       (x_br_resolve),
    .x_br_pc            (x_br_pc),
    .x_br_taken         (x_br_taken),
    .d_pc               (d_pc),
    .d_stall            (d_stall),
    .d_jump_req         (d_jump_req),
    .d_jump_target      (d_jump_target),
    .df_cir_lock        (df_cir_lock),
    .d_pred_taken       (d_pred_taken),
    .dx_pred_taken      (dx_pred_taken),
    .dx_mispredict_addr (dx_mispredict_addr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_pc, m_dx_addr;
  bit           m_lock, m_dx_pred;
  int           m_bht [DEPTH];

  // Model's view of this cycle's combinational outputs
  bit           e_stall, e_jreq, e_lock_out, e_pred, e_assert_lock;
  logic [W-1:0] e_target;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_lock    = 1'b0;
    m_dx_pred = 1'b0;
    m_dx_addr = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
  endtask

  function automatic int bht_index(input logic [W-1:0] addr);
    return int'((addr / 2) % DEPTH);
  endfunction

  task automatic model_comb();
`ifdef HAZARD5_BHT_EN
    e_pred = (m_bht[bht_index(m_pc)] >= 2);
`else
    e_pred = ($signed(d_imm_b) < 0);
`endif
    e_jreq        = d_instr_vld && !m_lock && (d_is_jal || (d_is_branch && e_pred));
    e_target      = m_pc + (d_is_jal ? d_imm_j : d_imm_b);
    e_stall       = x_stall || !d_instr_vld || (e_jreq && !f_jump_rdy);
    e_assert_lock = e_jreq && f_jump_rdy && e_stall;
    e_lock_out    = (m_lock && e_stall) || e_assert_lock;
  endtask

  // One clock cycle: inputs are already applied (called just after negedge).
  // With auto_jump, fetch takes any request it is ready for.
  task automatic cycle(input bit auto_jump);
    logic [W-1:0] len;
    int           idx;
    model_comb();
    if (auto_jump) begin
      f_jump_now    = e_jreq && f_jump_rdy;
      f_jump_target = e_target;
    end
    #1;
    check("d_pc", d_pc, m_pc);
    check("d_stall", 32'(d_stall), 32'(e_stall));
    check("d_jump_req", 32'(d_jump_req), 32'(e_jreq));
    check("d_jump_target", d_jump_target, e_target);
    check("df_cir_lock", 32'(df_cir_lock), 32'(e_lock_out));
    check("d_pred_taken", 32'(d_pred_taken), 32'(e_pred));
    check("dx_pred_taken", 32'(dx_pred_taken), 32'(m_dx_pred));
    check("dx_mispredict_addr", dx_mispredict_addr, m_dx_addr);
    len = d_instr_is_32bit ? 32'd4 : 32'd2;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_assert_lock || (!x_stall && !m_lock))
        m_dx_addr = (d_is_branch && !e_pred) ? m_pc + d_imm_b : m_pc + len;
      if (flush_d_x || (e_stall && !x_stall)) m_dx_pred = 1'b0;
      else if (!x_stall)                      m_dx_pred = d_is_branch && e_pred;
      if (f_jump_now)                m_pc = f_jump_target;
      else if (!e_stall && !m_lock)  m_pc = m_pc + len;
      m_lock = e_lock_out;
`ifdef HAZARD5_BHT_EN
      if (x_br_resolve) begin
        idx = bht_index(x_br_pc);
        if (x_br_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else            m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      end
`else
      idx = 0;
`endif
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 0; d_instr_vld = 0; d_instr_is_32bit = 1; d_is_branch = 0; d_is_jal = 0;
    d_imm_b = 0; d_imm_j = 0; x_stall = 0; flush_d_x = 0; f_jump_rdy = 0;
    f_jump_now = 0; f_jump_target = 0; x_br_resolve = 0; x_br_pc = 0; x_br_taken = 0;
  endtask

  // Move the PC by a fetch jump while no instruction is valid.
  task automatic goto_pc(input logic [W-1:0] addr);
    set_idle();
    f_jump_now    = 1;
    f_jump_target = addr;
    cycle(0);
    f_jump_now = 0;
  endtask

  initial begin
    int v;
    set_idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_pc", d_pc, 32'h0);
    check("rst_lock", 32'(df_cir_lock), 32'h0);
    check("rst_dx_pred", 32'(dx_pred_taken), 32'h0);
    check("rst_dx_addr", dx_mispredict_addr, 32'h0);

    // Sequential 32-bit then 16-bit advance
    d_instr_vld = 1;
    cycle(1);
    cycle(1);
    check("seq_pc_8", d_pc, 32'h8);
    d_instr_is_32bit = 0;
    cycle(1);
    check("seq_pc_16bit", d_pc, 32'hA);

    // Backward branch: predicted taken in static mode
    goto_pc(32'h100);
    d_instr_vld = 1; d_is_branch = 1; d_imm_b = -32'sd8; f_jump_rdy = 1;
    #1;
`ifndef HAZARD5_BHT_EN
    check("bwd_jump_req", 32'(d_jump_req), 32'h1);
`endif
    check("bwd_target", d_jump_target, 32'hF8);
    cycle(1);
`ifndef HAZARD5_BHT_EN
    check("bwd_dx_addr", dx_mispredict_addr, 32'h104);
    check("bwd_dx_pred", 32'(dx_pred_taken), 32'h1);
    check("bwd_pc", d_pc, 32'hF8);
`endif

    // Forward branch: predicted not taken
    goto_pc(32'h100);
    d_instr_vld = 1; d_is_branch = 1; d_imm_b = 32'd16; f_jump_rdy = 1;
    #1;
    check("fwd_jump_req", 32'(d_jump_req), 32'h0);
    cycle(1);
    check("fwd_dx_addr", dx_mispredict_addr, 32'h110);
    check("fwd_dx_pred", 32'(dx_pred_taken), 32'h0);

    // JAL accepted under a 3-cycle X stall: lock, no repeat request
    goto_pc(32'h200);
    d_instr_vld = 1; d_is_jal = 1; d_imm_j = 32'h40; x_stall = 1; f_jump_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lock_held", 32'(df_cir_lock), 32'h1);
      if (k > 0) begin
        check("no_rejump", 32'(d_jump_req), 32'h0);
        check("lock_dx_addr", dx_mispredict_addr, 32'h204);
      end
      cycle(1);
    end
    x_stall = 0;
    #1;
    check("lock_release", 32'(df_cir_lock), 32'h0);
    check("lock_pc", d_pc, 32'h240);
    cycle(1);
    check("post_lock_dx_addr", dx_mispredict_addr, 32'h204);
    d_is_jal = 0;

`ifdef HAZARD5_BHT_EN
    // Train taken three times at 0x40
    set_idle();
    x_br_resolve = 1; x_br_pc = 32'h40; x_br_taken = 1;
    repeat (3) cycle(0);
    goto_pc(32'h40);
    d_instr_vld = 1; d_is_branch = 1; d_imm_b = 32'd16; x_stall = 1;
    #1;
    check("bht_taken", 32'(d_pred_taken), 32'h1);
    x_br_resolve = 1; x_br_pc = 32'h40; x_br_taken = 0;
    repeat (2) cycle(1);
    x_br_resolve = 0;
    #1;
    check("bht_not_taken", 32'(d_pred_taken), 32'h0);
    x_br_resolve = 1; x_br_taken = 1;
    #1;
    check("bht_same_cycle_old", 32'(d_pred_taken), 32'h0);
    cycle(1);
    x_br_resolve = 0;
    #1;
    check("bht_after_update", 32'(d_pred_taken), 32'h1);
    cycle(1);
`endif

    // Reset in the middle of a lock
    goto_pc(32'h300);
    d_instr_vld = 1; d_is_jal = 1; d_imm_j = 32'h20; x_stall = 1; f_jump_rdy = 1;
    cycle(1);
    d_is_jal = 0;
    #1;
    check("lock_before_rst", 32'(df_cir_lock), 32'h1);
    rst = 1;
    cycle(1);
    rst = 0;
    #1;
    check("rst_mid_lock_lock", 32'(df_cir_lock), 32'h0);
    check("rst_mid_lock_pc", d_pc, 32'h0);
    check("rst_mid_lock_dx_addr", dx_mispredict_addr, 32'h0);
`ifdef HAZARD5_BHT_EN
    goto_pc(32'h40);
    d_instr_vld = 1; d_is_branch = 1; d_imm_b = 32'd16; x_stall = 1;
    #1;
    check("rst_bht_init", 32'(d_pred_taken), 32'h0);
    cycle(1);
`endif

    // Randomized cycles against the model
    for (int n = 0; n < 600; n++) begin
      bit auto_jump;
      set_idle();
      rst              = ($urandom_range(0, 63) == 0);
      d_instr_vld      = ($urandom_range(0, 3) != 0);
      d_instr_is_32bit = $urandom_range(0, 1) == 1;
      v = $urandom_range(0, 3);
      d_is_branch      = (v == 0);
      d_is_jal         = (v == 1);
      v = int'($urandom_range(0, 64)) * 2 - 64;
      d_imm_b          = 32'(v);
      v = int'($urandom_range(0, 256)) * 2 - 256;
      d_imm_j          = 32'(v);
      x_stall          = ($urandom_range(0, 3) == 0);
      flush_d_x        = ($urandom_range(0, 7) == 0);
      f_jump_rdy       = ($urandom_range(0, 3) != 0);
      x_br_resolve     = $urandom_range(0, 1) == 1;
      x_br_pc          = 32'($urandom_range(0, 63) * 2);
      x_br_taken       = $urandom_range(0, 1) == 1;
      auto_jump        = ($urandom_range(0, 15) != 0);
      if (!auto_jump) begin
        f_jump_now    = 1;
        f_jump_target = 32'($urandom_range(0, 32'hFFFF)) & ~32'h1;
      end
      cycle(auto_jump);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
